// File: rtl/data_unrotator_pkg.sv
// rtl/data_unrotator_pkg.sv - geometry constants and state encoding for the column-to-row unrotator
package data_unrotator_pkg;

  localparam int WORD_SIZE  = 128;
  localparam int UNROT_ROWS = 8;
  localparam int UNROT_COLS = 16;
  localparam int UNROT_BYTE = 8;

  typedef enum logic {
    UNROT_ST_COLLECT = 1'b0,
    UNROT_ST_EMIT    = 1'b1
  } unrot_state_e;

endpackage

// File: rtl/data_unrotator.sv
// rtl/data_unrotator.sv - rebuilds 8 row words from 16 byte-column words and streams them out in row order
module data_unrotator
  import data_unrotator_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 DI_valid,
  input  logic [WORD_SIZE-1:0] DI,
  output logic                 DI_ready,
  output logic                 DO_valid,
  input  logic                 DO_ready,
  output logic [WORD_SIZE-1:0] DO,
  output logic                 DO_last
);

  unrot_state_e state, state_nx;
  logic [3:0]   ccnt;
  logic [2:0]   ocnt;
  logic         accept;
  logic         xfer;
  logic [WORD_SIZE-1:0] rows_w [UNROT_ROWS];

  // Only the upper 64 bits of a column word carry row bytes.
  logic unused_di_low;
  assign unused_di_low = ^DI[WORD_SIZE/2-1:0];

  assign accept = DI_valid && DI_ready;
  assign xfer   = DO_valid && DO_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= UNROT_ST_COLLECT;
      ccnt  <= 4'd0;
      ocnt  <= 3'd0;
    end else begin
      state <= state_nx;
      if (accept) ccnt <= (ccnt == 4'(UNROT_COLS - 1)) ? 4'd0 : ccnt + 4'd1;
      if (xfer)   ocnt <= (ocnt == 3'(UNROT_ROWS - 1)) ? 3'd0 : ocnt + 3'd1;
    end
  end

  always_comb begin
    state_nx = state;
    DI_ready = 1'b0;
    DO_valid = 1'b0;
    DO       = '0;
    DO_last  = 1'b0;
    case (state)
      UNROT_ST_COLLECT: begin
        DI_ready = 1'b1;
        if (accept && ccnt == 4'(UNROT_COLS - 1)) state_nx = UNROT_ST_EMIT;
      end
      UNROT_ST_EMIT: begin
        DO_valid = 1'b1;
        DO       = rows_w[ocnt];
        DO_last  = (ocnt == 3'(UNROT_ROWS - 1));
        if (xfer && ocnt == 3'(UNROT_ROWS - 1)) state_nx = UNROT_ST_COLLECT;
      end
      default: state_nx = UNROT_ST_COLLECT;
    endcase
  end

  // Row r takes byte r of each column; column ccnt lands in byte lane ccnt of the row.
  for (genvar r = 0; r < UNROT_ROWS; r++) begin : gen_row
    logic [WORD_SIZE-1:0] row_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        row_q <= '0;
      end else if (accept) begin
        for (int c = 0; c < UNROT_COLS; c++) begin
          if (ccnt == 4'(c))
            row_q[WORD_SIZE-1-UNROT_BYTE*c -: UNROT_BYTE] <= DI[WORD_SIZE-1-UNROT_BYTE*r -: UNROT_BYTE];
        end
      end
    end

    assign rows_w[r] = row_q;
  end

endmodule

// File: tb/tb_data_unrotator.sv
// tb/tb_data_unrotator.sv - directed self-checking bench for data_unrotator
module tb_data_unrotator;

  typedef logic [127:0] blk_t [8];
  typedef logic [127:0] col_t [16];

  logic         clk;
  logic         rst;
  logic         DI_valid;
  logic [127:0] DI;
  logic         DI_ready;
  logic         DO_valid;
  logic         DO_ready;
  logic [127:0] DO;
  logic         DO_last;

  int n_vec;
  int n_fail;

  data_unrotator dut (
    .clk      (clk),
    .rst      (rst),
    .DI_valid (DI_valid),
    .DI       (DI),
    .DI_ready (DI_ready),
    .DO_valid (DO_valid),
    .DO_ready (DO_ready),
    .DO       (DO),
    .DO_last  (DO_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // Forward byte-column rotator: column k byte r = row r byte k.
  function automatic col_t rotate(input blk_t rows);
    col_t c;
    for (int k = 0; k < 16; k++) begin
      c[k] = {$urandom, $urandom, $urandom, $urandom};
      for (int r = 0; r < 8; r++)
        c[k][127-8*r -: 8] = rows[r][127-8*k -: 8];
    end
    return c;
  endfunction

  function automatic col_t cols_single();
    col_t c;
    for (int k = 0; k < 16; k++)
      c[k] = {{8{8'(16*k)}}, 64'hFFFF_FFFF_FFFF_FFFF};
    return c;
  endfunction

  function automatic col_t cols_distinct();
    col_t c;
    for (int k = 0; k < 16; k++) begin
      c[k] = {64'd0, $urandom, $urandom};
      for (int r = 0; r < 8; r++)
        c[k][127-8*r -: 8] = 8'((r << 4) | k);
    end
    return c;
  endfunction

  function automatic blk_t exp_distinct();
    blk_t e;
    e[0] = 128'h000102030405060708090A0B0C0D0E0F;
    e[1] = 128'h101112131415161718191A1B1C1D1E1F;
    e[2] = 128'h202122232425262728292A2B2C2D2E2F;
    e[3] = 128'h303132333435363738393A3B3C3D3E3F;
    e[4] = 128'h404142434445464748494A4B4C4D4E4F;
    e[5] = 128'h505152535455565758595A5B5C5D5E5F;
    e[6] = 128'h606162636465666768696A6B6C6D6E6F;
    e[7] = 128'h707172737475767778797A7B7C7D7E7F;
    return e;
  endfunction

  localparam logic [127:0] SINGLE_ROW = 128'h00102030405060708090A0B0C0D0E0F0;

  // Starts and ends at a falling edge; each column accepted on the following rising edge.
  task automatic send_block(input col_t cols, input int ncols, input int max_gap, input bit hold_valid);
    int gaps;
    for (int k = 0; k < ncols; k++) begin
      gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gaps) begin
        DI_valid = 1'b0;
        DI       = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); @(negedge clk);
      end
      DI_valid = 1'b1;
      DI       = cols[k];
      @(posedge clk); @(negedge clk);
    end
    DI_valid = hold_valid;
    DI       = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678;
  endtask

  task automatic recv_block(output blk_t rows, output logic [7:0] lasts, output bit first_now,
                            output bit timed_out, output bit ready_in_emit);
    int n;
    int cyc;
    n = 0; cyc = 0; timed_out = 1'b0; ready_in_emit = 1'b0; lasts = '0;
    for (int i = 0; i < 8; i++) rows[i] = '0;
    DO_ready  = 1'b1;
    first_now = DO_valid;
    while (n < 8) begin
      if (cyc > 64) begin
        timed_out = 1'b1;
        break;
      end
      if (DO_valid) begin
        if (DI_ready) ready_in_emit = 1'b1;
        rows[n]  = DO;
        lasts[n] = DO_last;
        n++;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    DI_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; DI_valid = 1'b0; DI = '0; DO_ready = 1'b1;
    #3;
    n_vec++; if (DO_valid !== 1'b0) begin n_fail++; $display("FAIL reset_do_valid got %b want 0", DO_valid); end
    n_vec++; if (DI_ready !== 1'b1) begin n_fail++; $display("FAIL reset_di_ready got %b want 1", DI_ready); end
    n_vec++; if (DO !== 128'd0) begin n_fail++; $display("FAIL reset_do got %h want 0", DO); end
    n_vec++; if (DO_last !== 1'b0) begin n_fail++; $display("FAIL reset_do_last got %b want 0", DO_last); end
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_single_block();
    blk_t got; logic [7:0] lasts; bit first_now, to, rie;
    send_block(cols_single(), 16, 0, 1'b0);
    recv_block(got, lasts, first_now, to, rie);
    n_vec++; if (first_now !== 1'b1) begin n_fail++; $display("FAIL single_latency do_valid got %b want 1", first_now); end
    n_vec++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout got %b want 0", to); end
    for (int r = 0; r < 8; r++) begin
      n_vec++;
      if (got[r] !== SINGLE_ROW) begin n_fail++; $display("FAIL single_row%0d got %h want %h", r, got[r], SINGLE_ROW); end
    end
    n_vec++; if (lasts !== 8'b1000_0000) begin n_fail++; $display("FAIL single_last got %b want 10000000", lasts); end
    n_vec++; if (rie !== 1'b0) begin n_fail++; $display("FAIL single_ready_in_emit got %b want 0", rie); end
    n_vec++; if (DI_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_after got %b want 1", DI_ready); end
  endtask

  task automatic test_row_distinct();
    blk_t got; blk_t e; logic [7:0] lasts; bit first_now, to, rie;
    e = exp_distinct();
    send_block(cols_distinct(), 16, 0, 1'b0);
    recv_block(got, lasts, first_now, to, rie);
    n_vec++; if (to !== 1'b0) begin n_fail++; $display("FAIL distinct_timeout got %b want 0", to); end
    for (int r = 0; r < 8; r++) begin
      n_vec++;
      if (got[r] !== e[r]) begin n_fail++; $display("FAIL distinct_row%0d got %h want %h", r, got[r], e[r]); end
    end
    n_vec++; if (lasts !== 8'b1000_0000) begin n_fail++; $display("FAIL distinct_last got %b want 10000000", lasts); end
  endtask

  task automatic test_backpressure();
    blk_t e; int n; int stalls; int cyc; int lasts_seen;
    e = exp_distinct();
    send_block(cols_distinct(), 16, 0, 1'b0);
    n = 0; stalls = 0; cyc = 0; lasts_seen = 0;
    while (n < 8 && cyc < 64) begin
      if (n == 3 && stalls < 5) begin
        DO_ready = 1'b0;
        n_vec++;
        if (DO !== e[3] || DO_valid !== 1'b1 || DI_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_hold%0d got do=%h v=%b rdy=%b want do=%h v=1 rdy=0", stalls, DO, DO_valid, DI_ready, e[3]);
        end
        stalls++;
      end else begin
        DO_ready = 1'b1;
        if (DO_valid) begin
          n_vec++;
          if (DO !== e[n] || DI_ready !== 1'b0 || DO_last !== (n == 7)) begin
            n_fail++;
            $display("FAIL bp_row%0d got do=%h last=%b rdy=%b want do=%h last=%b rdy=0", n, DO, DO_last, DI_ready, e[n], n == 7);
          end
          if (DO_last) lasts_seen++;
          n++;
        end
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    n_vec++; if (n !== 8) begin n_fail++; $display("FAIL bp_row_count got %0d want 8", n); end
    n_vec++; if (lasts_seen !== 1) begin n_fail++; $display("FAIL bp_last_count got %0d want 1", lasts_seen); end
    n_vec++; if (DO_valid !== 1'b0 || DI_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_after got v=%b rdy=%b want v=0 rdy=1", DO_valid, DI_ready);
    end
    DO_ready = 1'b1;
  endtask

  task automatic test_gaps_stall();
    blk_t got; blk_t e; logic [7:0] lasts; bit first_now, to, rie;
    e = exp_distinct();
    send_block(cols_distinct(), 16, 3, 1'b1);
    recv_block(got, lasts, first_now, to, rie);
    n_vec++; if (to !== 1'b0) begin n_fail++; $display("FAIL gaps_timeout got %b want 0", to); end
    for (int r = 0; r < 8; r++) begin
      n_vec++;
      if (got[r] !== e[r]) begin n_fail++; $display("FAIL gaps_row%0d got %h want %h", r, got[r], e[r]); end
    end
    // A consumed EMIT-phase word would shift the next block by one column.
    send_block(cols_single(), 16, 0, 1'b0);
    recv_block(got, lasts, first_now, to, rie);
    for (int r = 0; r < 8; r++) begin
      n_vec++;
      if (got[r] !== SINGLE_ROW) begin n_fail++; $display("FAIL stall_next_row%0d got %h want %h", r, got[r], SINGLE_ROW); end
    end
    n_vec++; if (first_now !== 1'b1) begin n_fail++; $display("FAIL stall_next_latency got %b want 1", first_now); end
  endtask

  task automatic test_reset_mid();
    col_t junk; blk_t got; logic [7:0] lasts; bit first_now, to, rie;
    for (int k = 0; k < 16; k++) junk[k] = {128{1'b1}} ^ 128'(k);
    send_block(junk, 9, 0, 1'b0);
    rst = 1'b0;
    #1;
    n_vec++; if (DO_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_do_valid got %b want 0", DO_valid); end
    n_vec++; if (DI_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_di_ready got %b want 1", DI_ready); end
    repeat (2) begin @(posedge clk); @(negedge clk); end
    n_vec++; if (DO_valid !== 1'b0 || DI_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_hold got v=%b rdy=%b want v=0 rdy=1", DO_valid, DI_ready);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    send_block(cols_single(), 16, 0, 1'b0);
    recv_block(got, lasts, first_now, to, rie);
    n_vec++; if (first_now !== 1'b1) begin n_fail++; $display("FAIL midrst_latency got %b want 1", first_now); end
    for (int r = 0; r < 8; r++) begin
      n_vec++;
      if (got[r] !== SINGLE_ROW) begin n_fail++; $display("FAIL midrst_row%0d got %h want %h", r, got[r], SINGLE_ROW); end
    end
  endtask

  task automatic test_back_to_back();
    blk_t orig; blk_t got; logic [7:0] lasts; bit first_now, to, rie;
    for (int b = 0; b < 3; b++) begin
      for (int r = 0; r < 8; r++) orig[r] = {$urandom, $urandom, $urandom, $urandom};
      send_block(rotate(orig), 16, 0, 1'b0);
      recv_block(got, lasts, first_now, to, rie);
      n_vec++; if (first_now !== 1'b1 || to !== 1'b0) begin
        n_fail++; $display("FAIL rt%0d_handshake got first=%b to=%b want first=1 to=0", b, first_now, to);
      end
      for (int r = 0; r < 8; r++) begin
        n_vec++;
        if (got[r] !== orig[r]) begin n_fail++; $display("FAIL rt%0d_row%0d got %h want %h", b, r, got[r], orig[r]); end
      end
      n_vec++; if (lasts !== 8'b1000_0000) begin n_fail++; $display("FAIL rt%0d_last got %b want 10000000", b, lasts); end
    end
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    test_reset();
    test_single_block();
    test_row_distinct();
    test_backpressure();
    test_gaps_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/data_unrotator.md
# data_unrotator

Inverse of the byte-column rotator in the max/writeback path. It collects 16 column words, each carrying one byte from each of 8 rows in its upper 64 bits. It rebuilds the 8 original 128-bit row words and streams them out in row order with a valid/ready handshake. It sits between the rotated-data stream and the writeback buffer, so that column-major results return to row-major layout.

## Interface
- Parameters: none. Widths come from `` `WORD_SIZE `` (128) in define.v. Block geometry is fixed at 8 rows × 16 byte columns.
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- DI_valid  in  1  input column word valid
- DI  in  `WORD_SIZE`  column word: DI[127:120]=row0 byte, DI[119:112]=row1 … DI[71:64]=row7; DI[63:0] ignored
- DI_ready  out  1  block can accept a column word
- DO_valid  out  1  output row word valid
- DO_ready  in  1  downstream accepts row word
- DO  out  `WORD_SIZE`  reconstructed row word
- DO_last  out  1  high with row 7 (final row of block)

## Operation
- States: COLLECT (reset state), EMIT.
- Accept = DI_valid && DI_ready. Transfer = DO_valid && DO_ready.
- COLLECT:
  - DI_ready=1, DO_valid=0.
  - On accept of column ccnt (0..15), byte r of DI (bits [127-8r -: 8]) is written into row r at bits [127-8·ccnt -: 8] for r=0..7.
  - ccnt increments on each accept. After the accept at ccnt=15, ccnt←0 and the state moves to EMIT.
- EMIT:
  - DI_ready=0, DO_valid=1, DO=row[ocnt], DO_last=(ocnt==7).
  - On each transfer, ocnt increments. On the transfer at ocnt=7, ocnt←0 and the state moves to COLLECT.
  - While DO_ready=0, DO, DO_valid and DO_last hold stable.
- Buffer: 8×128-bit registers. Every byte is rewritten each block, so no clear is needed between blocks.
- Outputs outside EMIT: DO=0, DO_last=0.
- Round trip: feeding the forward rotator's 16 output words back in reproduces its 8 input words bit-exactly.

## Timing
- Reset (rst=0, async) sets:
  - state=COLLECT, ccnt=0, ocnt=0, all buffer bytes=0
  - DO_valid=0, DO=0, DO_last=0
  - DI_ready=1 (decoded from the state)
- DI_ready, DO_valid, DO and DO_last are decoded combinationally from registered state and counters. There is no combinational path from DI_valid or DO_ready to any output.
- Latency: the 16th accept occurs at edge N. Row 0 is presented with DO_valid=1 in the cycle after edge N.
- With DO_ready held high, rows 0..7 occupy 8 consecutive cycles. DI_ready returns to 1 in the cycle after the row-7 transfer.
- Minimum block period is 24 cycles (16 in, 8 out). Input and output do not overlap.
- DI_valid gaps during COLLECT are allowed. Counters and buffer hold on idle cycles.
- DI_valid during EMIT is not accepted. DI is ignored and upstream must hold.
- Reset mid-block discards partial columns and unsent rows. The next block starts at ccnt=0.

## Structure
- define.v holds:
  - `WORD_SIZE`
  - new constants: `UNROT_ROWS` (8), `UNROT_COLS` (16), `UNROT_BYTE` (8)
  - state encodings: `UNROT_ST_COLLECT`, `UNROT_ST_EMIT`
- Single module: data_unrotator, with no sub-modules. The byte-lane write is a generate loop over rows. Counters are 4-bit (ccnt) and 3-bit (ocnt).

## Test plan
- Single block, DO_ready=1:
  - Stimulus: column k = {8{8'(16·k)}} in [127:64], 64'hFFFF… in [63:0].
  - Required: 8 rows, every row = 128'h00102030…F0, DO_last on row 7 only, first DO_valid one cycle after the 16th accept.
- Row-distinct pattern:
  - Stimulus: byte r of column k = 8'(r<<4 | k).
  - Required: row r = {r0,r1,…,rF} nibble-pairs, e.g. row 2 = 128'h202122…2F.
- Backpressure:
  - Stimulus: DO_ready=0 for 5 cycles at ocnt=3.
  - Required: DO=row3 held stable, DO_valid=1, no row skipped or duplicated. DI_ready=0 throughout.
- Input gaps and stall:
  - Stimulus: random DI_valid gaps during COLLECT, plus DI_valid=1 during EMIT.
  - Required: output identical to the gap-free case. EMIT-phase input is not consumed.
- Reset mid-block:
  - Stimulus: assert rst after 9 columns, release, then send a full new block.
  - Required: DO_valid=0 and DI_ready=1 during reset. The output contains only the new block's data, with zeros nowhere unexpected.
- Round trip:
  - Stimulus: forward rotator output fed into this block over 3 back-to-back random blocks.
  - Required: exact match to the original 8 row words per block.
